i2c_target: RTL and testbench

I2C target (slave) that answers a 7-bit addressed controller on the shared SCL/SDA bus. It oversamples both lines with the local system clock and detects START/STOP and SCL edges. On controller writes it shifts in address and data bytes and hands each byte to local logic. On controller reads it requests bytes from local logic and shifts them out, driving SDA open-drain only for ACK and read data.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_sync.sv | 35 +++
 rtl/i2c_target.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit/ACK constants and the
// address-match helper. The helper honours I2C_TARGET_GENERAL_CALL_EN:
// when defined, the general-call write address (8'h00) also matches.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck
    } i2c_state_e;

    localparam int unsigned BIT_COUNT         = 8;
    localparam logic        ACK               = 1'b0;
    localparam logic        NACK              = 1'b1;
    localparam logic [6:0]  GENERAL_CALL_ADDR = 7'h00;

    // True when the received address byte {addr, rw} selects this target.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        logic hit;
        hit = (addr_byte[7:1] == own_addr);
`ifdef I2C_TARGET_GENERAL_CALL_EN
        // General call is write-only; a read to 7'h00 stays a mismatch.
        hit = hit | (addr_byte == {GENERAL_CALL_ADDR, 1'b0});
`endif
        return hit;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line synchronizer: SYNC_STAGES flops into the clk domain, then a
// previous-sample register to produce single-clk rise/fall pulses.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge pulses from the synchronized level against the previous sample.
    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        rise  = level & ~prev_q;
        fall  = ~level & prev_q;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing. Oversamples SCL/SDA, decodes START/STOP
// and SCL edges, receives write bytes and serves read bytes on request.
// SDA is only ever pulled low (ACK or a 0 read bit), otherwise released.
// Optional build macro: I2C_TARGET_GENERAL_CALL_EN (ACK general-call writes).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       rw_dir,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(BIT_COUNT - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] byte_in;
    logic       sda_oe_q, sda_oe_d;
    // ACK states: ACK drive active (Addr/WrAck) or ACK sampled (RdAck).
    logic       ack_phase_q, ack_phase_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_hit_q, addr_hit_d;
    logic       rw_dir_q, rw_dir_d;
    logic       busy_q, busy_d;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .line (scl),
        .level(scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .line (sda),
        .level(sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // Open-drain drive straight from a register, so reset releases it at once.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Bus condition decode: SDA edges while SCL is high.
    always_comb begin
        start_cond = sda_fall & scl_lvl;
        stop_cond  = sda_rise & scl_lvl;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            sda_oe_q    <= 1'b0;
            ack_phase_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            addr_hit_q  <= 1'b0;
            rw_dir_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            ack_phase_q <= ack_phase_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            addr_hit_q  <= addr_hit_d;
            rw_dir_q    <= rw_dir_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; START/STOP take priority over any SCL edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        ack_phase_d = ack_phase_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        addr_hit_d  = 1'b0;
        rw_dir_d    = rw_dir_q;
        busy_d      = busy_q;
        byte_in     = {shift_q[6:0], sda_lvl};

        if (start_cond) begin
            state_d     = StAddr;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
        end else if (stop_cond) begin
            state_d     = StIdle;
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            if (addr_match(byte_in, TARGET_ADDR)) begin
                                addr_hit_d  = 1'b1;
                                rw_dir_d    = byte_in[0];
                                busy_d      = 1'b1;
                                tx_req_d    = byte_in[0];
                                ack_phase_d = 1'b0;
                                state_d     = StAddrAck;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StAddrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            // 8th falling edge: pull SDA low for the ACK bit.
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            // 9th falling edge: ACK done, start the next byte.
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = '0;
                            if (rw_dir_q) begin
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[7];
                                state_d  = StRdData;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = StWrData;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = byte_in;
                            rx_valid_d  = 1'b1;
                            ack_phase_d = 1'b0;
                            state_d     = StWrAck;
                        end
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        // Counter wrapped to 0 means all 8 bits have been clocked.
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            state_d     = StRdAck;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (sda_lvl == ACK) begin
                            tx_req_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = StIdle;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = '0;
                        shift_d     = tx_data;
                        sda_oe_d    = ~tx_data[7];
                        state_d     = StRdData;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Registered outputs.
    always_comb begin
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        tx_req   = tx_req_q;
        addr_hit = addr_hit_q;
        rw_dir   = rw_dir_q;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller drives SCL/SDA and
// hand-computed bytes, ACKs and pulse counts are compared against the target.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int QTR = 10;  // clk cycles per quarter SCL period

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda_low;
    wire        sda_bus;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_hit;
    logic       rw_dir;
    logic       busy;

    int n_checks;
    int n_fails;
    int rx_cnt;
    int tx_cnt;
    int hit_cnt;
    int drv_cnt;
    logic [7:0] tx_tab [4];

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    assign tx_data = tx_tab[tx_cnt[1:0]];

    i2c_target #(
        .TARGET_ADDR(7'h42),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda_bus),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .addr_hit(addr_hit),
        .rw_dir  (rw_dir),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and a count of clks where the target itself pulls SDA low.
    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (addr_hit) hit_cnt <= hit_cnt + 1;
        if (sda_bus === 1'b0 && !sda_low) drv_cnt <= drv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qwait();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b1; qwait();
        scl = 1'b0;     qwait();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; qwait();
        scl = 1'b1;     qwait();
        sda_low = 1'b0; qwait();
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b; qwait();
        scl = 1'b1;   qwait();
        qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic sample_bit(output logic b);
        sda_low = 1'b0; qwait();
        scl = 1'b1;     qwait();
        b = sda_bus;    qwait();
        scl = 1'b0;     qwait();
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        sample_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) sample_bit(data[i]);
        send_bit(ack);
        sda_low = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx0, tx0, hit0, drv0;

        n_checks = 0;
        n_fails  = 0;
        rx_cnt   = 0;
        tx_cnt   = 0;
        hit_cnt  = 0;
        drv_cnt  = 0;
        for (int i = 0; i < 4; i++) tx_tab[i] = 8'h00;
        scl     = 1'b1;
        sda_low = 1'b0;
        rst     = 1'b1;
        repeat (5) @(negedge clk);

        check("reset_sda", sda_bus, 1'b1);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_rw_dir", rw_dir, 1'b0);
        check("reset_pulses", {rx_valid, tx_req, addr_hit}, 3'b000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write A5 to 7'h42.
        rx0 = rx_cnt; hit0 = hit_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", ack, ACK);
        check("wr_rw_dir", rw_dir, 1'b0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, ACK);
        check("wr_rx_data", rx_data, 8'hA5);
        check("wr_rx_count", rx_cnt - rx0, 1);
        check("wr_hit_count", hit_cnt - hit0, 1);
        check("wr_busy", busy, 1'b1);
        i2c_stop();
        check("wr_busy_after_stop", busy, 1'b0);

        // Read two bytes: ACK 3C, NACK C3.
        tx_tab[(tx_cnt + 1) % 4] = 8'h3C;
        tx_tab[(tx_cnt + 2) % 4] = 8'hC3;
        tx0 = tx_cnt;
        i2c_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", ack, ACK);
        check("rd_rw_dir", rw_dir, 1'b1);
        read_byte(ACK, rd);
        check("rd_byte1", rd, 8'h3C);
        read_byte(NACK, rd);
        check("rd_byte2", rd, 8'hC3);
        check("rd_tx_req_count", tx_cnt - tx0, 2);
        check("rd_busy_after_nack", busy, 1'b0);
        check("rd_state_idle", dut.state_q, StIdle);
        i2c_stop();

        // Non-matching address 7'h43, then a byte that must be ignored.
        rx0 = rx_cnt; hit0 = hit_cnt; drv0 = drv_cnt;
        i2c_start();
        write_byte(8'h86, ack);
        check("miss_addr_nack", ack, NACK);
        write_byte(8'h84, ack);
        check("miss_data_nack", ack, NACK);
        check("miss_no_drive", drv_cnt - drv0, 0);
        check("miss_no_hit", hit_cnt - hit0, 0);
        check("miss_no_rx", rx_cnt - rx0, 0);
        check("miss_busy", busy, 1'b0);
        i2c_stop();

        // Write 11, repeated START, read one byte.
        tx_tab[(tx_cnt + 1) % 4] = 8'h96;
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        check("rs_wr_addr_ack", ack, ACK);
        check("rs_rw_dir_wr", rw_dir, 1'b0);
        write_byte(8'h11, ack);
        check("rs_wr_data_ack", ack, ACK);
        i2c_start();
        write_byte(8'h85, ack);
        check("rs_rd_addr_ack", ack, ACK);
        check("rs_rw_dir_rd", rw_dir, 1'b1);
        read_byte(NACK, rd);
        check("rs_rd_byte", rd, 8'h96);
        check("rs_rx_count", rx_cnt - rx0, 1);
        check("rs_rx_data", rx_data, 8'h11);
        i2c_stop();

        // Reset while the target holds the address ACK low.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
        sda_low = 1'b0;
        @(negedge clk);
        check("rst_ack_driving", sda_bus, 1'b0);
        check("rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_sda_released", sda_bus, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_outputs", {rx_valid, tx_req, addr_hit, rw_dir}, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        scl = 1'b1;
        qwait();
        i2c_start();
        write_byte(8'h84, ack);
        check("post_rst_addr_ack", ack, ACK);
        write_byte(8'h5A, ack);
        check("post_rst_data_ack", ack, ACK);
        check("post_rst_rx_data", rx_data, 8'h5A);
        i2c_stop();

        // General call write.
        hit0 = hit_cnt;
        i2c_start();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GENERAL_CALL_EN
        check("gc_ack", ack, ACK);
        check("gc_hit_count", hit_cnt - hit0, 1);
        check("gc_rw_dir", rw_dir, 1'b0);
`else
        check("gc_nack", ack, NACK);
        check("gc_hit_count", hit_cnt - hit0, 0);
        check("gc_busy", busy, 1'b0);
`endif
        i2c_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
